// File: rtl/sram_dp_pkg.sv
// Shared types for the SRAM datapath controller.
//   op_t    : command encoding presented on op_code
//   state_t : controller FSM states
package sram_dp_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_COPY  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sram_datapath_ctrl_flex_counter.sv
// Parametrised rollover counter.
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous return to zero (wins over count_enable)
//   count_enable  : advance by one; wraps to zero after rollover_val
//   rollover_val  : terminal count
//   count_out     : current count
//   rollover_flag : high while count_out equals rollover_val
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         count_enable,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out,
    output logic         rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + W'(1);
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/sram_datapath_ctrl.sv
// Single-port SRAM command sequencer: NOP / READ / WRITE / multi-word COPY
// behind a start/busy/done handshake, with a configurable read latency.
//   clk, n_rst               : clock, asynchronous active-low reset
//   start, op_code           : command request (taken only in IDLE)
//   address_one, address_two : source (or READ/WRITE) address, COPY destination
//   length                   : COPY moves length+1 words
//   data_in                  : WRITE data
//   data_out                 : last word read, held until the next capture
//   busy, done               : handshake status
//   sram_re, sram_we, sram_addr, sram_wdata, sram_rdata : SRAM port
// Every output is a register or a decode of registers only.
module sram_datapath_ctrl
    import sram_dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 7,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] address_one,
    input  logic [ADDR_W-1:0] address_two,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int              LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT - 1);

    state_t state, next_state;

    op_t               op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] buf_q;

    logic              accept;
    logic              is_copy;
    logic              lat_last;
    logic [LAT_W-1:0]  lat_count_unused;
    logic [LEN_W-1:0]  word_cnt;
    logic              word_last;
    logic [ADDR_W-1:0] offset;

    assign accept  = (state == ST_IDLE) && start;
    assign is_copy = (op_q == OP_COPY);

    // Read-latency timer: zeroed while issuing, counts through RD_WAIT and
    // flags the final wait cycle, where the read data is captured.
    flex_counter #(.W(LAT_W)) u_lat_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state == ST_RD_ISSUE),
        .count_enable  (state == ST_RD_WAIT),
        .rollover_val  (LAT_MAX),
        .count_out     (lat_count_unused),
        .rollover_flag (lat_last)
    );

    // Word counter: counts completed COPY words up to the latched length.
    // Its value doubles as the address offset from both base addresses, so
    // source and destination advance together and wrap modulo 2^ADDR_W.
    flex_counter #(.W(LEN_W)) u_word_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (accept),
        .count_enable  ((state == ST_WR) && is_copy && !word_last),
        .rollover_val  (len_q),
        .count_out     (word_cnt),
        .rollover_flag (word_last)
    );

    assign offset = ADDR_W'(word_cnt);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op_code)
                        OP_NOP:   next_state = ST_DONE;
                        OP_WRITE: next_state = ST_WR;
                        default:  next_state = ST_RD_ISSUE;
                    endcase
                end
            end
            ST_RD_ISSUE: next_state = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (lat_last) begin
                    next_state = is_copy ? ST_WR : ST_DONE;
                end
            end
            ST_WR: begin
                next_state = (is_copy && !word_last) ? ST_RD_ISSUE : ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Command latch at acceptance; read capture at the end of RD_WAIT.
    // For WRITE the destination is address_one and the buffer holds data_in,
    // so the WR state drives dst_q/buf_q regardless of the command.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_q     <= OP_NOP;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            buf_q    <= '0;
            data_out <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_t'(op_code);
                src_q <= address_one;
                dst_q <= (op_code == OP_WRITE) ? address_one : address_two;
                len_q <= length;
                buf_q <= data_in;
            end
            if ((state == ST_RD_WAIT) && lat_last) begin
                buf_q    <= sram_rdata;
                data_out <= sram_rdata;
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign sram_re    = (state == ST_RD_ISSUE);
    assign sram_we    = (state == ST_WR);
    assign sram_addr  = (state == ST_RD_ISSUE) ? src_q + offset :
                        (state == ST_WR)       ? dst_q + offset : '0;
    assign sram_wdata = (state == ST_WR) ? buf_q : '0;

endmodule

// File: tb/tb_sram_datapath_ctrl.sv
// Self-checking bench: two controllers (read latency 1 and 3) share one
// command stream; each drives its own behavioural SRAM. Results are compared
// against a word-level reference of the command semantics.
module tb_sram_datapath_ctrl;

    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WRT = 2'b10, CPY = 2'b11;
    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [6:0]  address_one = '0;
    logic [6:0]  address_two = '0;
    logic [6:0]  length = '0;
    logic [31:0] data_in = '0;
    logic        init_mem = 1'b0;

    logic [31:0] dout_s  [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        re_s    [2];
    logic        we_s    [2];
    logic [6:0]  addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];

    logic [31:0] mem  [2][128];
    logic [31:0] pipe [2][3];
    logic [31:0] ref_mem [128];
    logic [31:0] exp_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_datapath_ctrl #(.DATA_W(32), .ADDR_W(7), .LEN_W(7), .RD_LAT(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .start(start), .op_code(op_code),
        .address_one(address_one), .address_two(address_two), .length(length),
        .data_in(data_in), .data_out(dout_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .sram_re(re_s[0]), .sram_we(we_s[0]), .sram_addr(addr_s[0]),
        .sram_wdata(wdata_s[0]), .sram_rdata(rdata_s[0])
    );

    sram_datapath_ctrl #(.DATA_W(32), .ADDR_W(7), .LEN_W(7), .RD_LAT(3)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .start(start), .op_code(op_code),
        .address_one(address_one), .address_two(address_two), .length(length),
        .data_in(data_in), .data_out(dout_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .sram_re(re_s[1]), .sram_we(we_s[1]), .sram_addr(addr_s[1]),
        .sram_wdata(wdata_s[1]), .sram_rdata(rdata_s[1])
    );

    function automatic logic [31:0] pat(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural SRAMs: read data appears LAT cycles after the strobe
    // cycle; junk is shifted in when no read was issued.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (init_mem) begin
                for (int a = 0; a < 128; a++) mem[i][a] <= pat(a);
            end else if (we_s[i]) begin
                mem[i][addr_s[i]] <= wdata_s[i];
            end
            pipe[i][0] <= re_s[i] ? mem[i][addr_s[i]] : $urandom;
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    always_comb begin
        rdata_s[0] = pipe[0][0];
        rdata_s[1] = pipe[1][2];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            assert (!(re_s[i] && we_s[i])) else begin
                errors++;
                $error("FAIL strobe_overlap inst%0d: observed re=%b we=%b required not both", i, re_s[i], we_s[i]);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 2; i++) begin
            int bad = 0;
            int first = -1;
            for (int a = 0; a < 128; a++) begin
                if (mem[i][a] !== ref_mem[a]) begin
                    bad++;
                    if (first < 0) first = a;
                end
            end
            checks++;
            assert (bad == 0) else begin
                errors++;
                $error("FAIL %s inst%0d: observed %0d bad words (first at %0h) expected 0", tag, i, bad, first);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_inst%0d", tag, i),
                  {busy_s[i], done_s[i], re_s[i], we_s[i], addr_s[i], wdata_s[i]}, 64'd0);
            check($sformatf("%s_dout_inst%0d", tag, i), dout_s[i], 64'd0);
        end
    endtask

    // Issue one command, follow both controllers cycle by cycle, and compare
    // timing, strobe counts, read data and SRAM contents with the reference.
    task automatic run_cmd(input logic [1:0] op, input logic [6:0] a1, input logic [6:0] a2,
                           input logic [6:0] len, input logic [31:0] din,
                           input bit hold, input int poke);
        int n, exp_done, exp_re1, exp_we1, exp_nre, exp_nwe;
        int got_done [2];
        int got_re1 [2];
        int got_we1 [2];
        int nre [2];
        int nwe [2];
        logic [31:0] got_dout [2];
        logic finished;
        logic [6:0] s, d;
        logic [31:0] w;

        n = (op == CPY) ? int'(len) + 1 : 1;
        case (op)
            RD:  exp_dout = ref_mem[a1];
            WRT: ref_mem[a1] = din;
            CPY: begin
                for (int k = 0; k < n; k++) begin
                    s = a1 + 7'(k);
                    d = a2 + 7'(k);
                    w = ref_mem[s];
                    ref_mem[d] = w;
                    exp_dout = w;
                end
            end
            default: ;
        endcase

        for (int i = 0; i < 2; i++) begin
            got_done[i] = 0; got_re1[i] = 0; got_we1[i] = 0; nre[i] = 0; nwe[i] = 0;
            got_dout[i] = '0;
        end

        @(negedge clk);
        op_code = op; address_one = a1; address_two = a2; length = len; data_in = din;
        start = 1'b1;
        @(posedge clk);
        #1 start = hold;
        finished = 1'b0;
        for (int c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk);
            finished = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (got_done[i] == 0) begin
                    if (re_s[i]) begin nre[i]++; if (got_re1[i] == 0) got_re1[i] = c; end
                    if (we_s[i]) begin nwe[i]++; if (got_we1[i] == 0) got_we1[i] = c; end
                    if (done_s[i]) begin got_done[i] = c; got_dout[i] = dout_s[i]; end
                end else begin
                    if (!hold && c == got_done[i] + 1)
                        check($sformatf("busy_after_done_inst%0d", i), busy_s[i], 1'b0);
                    if (hold && c == got_done[i] + 2) begin
                        check($sformatf("reaccept_busy_inst%0d", i), busy_s[i], 1'b1);
                        check($sformatf("reaccept_re_inst%0d", i), re_s[i], 1'b1);
                    end
                end
                if (c == 1) check($sformatf("busy_c1_inst%0d", i), busy_s[i], 1'b1);
                if (got_done[i] == 0 || c < got_done[i] + (hold ? 2 : 1)) finished = 1'b0;
            end
            start = hold || (c + 1 == poke);
        end
        check("cmd_completed", finished, 1'b1);
        start = 1'b0;

        for (int i = 0; i < 2; i++) begin
            exp_done = (op == NOP) ? 1 : (op == WRT) ? 2 : (op == RD) ? 2 + LAT[i]
                                   : n * (2 + LAT[i]) + 1;
            exp_nre  = (op == RD || op == CPY) ? n : 0;
            exp_nwe  = (op == WRT || op == CPY) ? n : 0;
            exp_re1  = (exp_nre > 0) ? 1 : 0;
            exp_we1  = (op == WRT) ? 1 : (op == CPY) ? 2 + LAT[i] : 0;
            check($sformatf("done_cycle_op%0d_inst%0d", op, i), got_done[i], exp_done);
            check($sformatf("re_count_inst%0d", i), nre[i], exp_nre);
            check($sformatf("we_count_inst%0d", i), nwe[i], exp_nwe);
            check($sformatf("first_re_inst%0d", i), got_re1[i], exp_re1);
            check($sformatf("first_we_inst%0d", i), got_we1[i], exp_we1);
            check($sformatf("data_out_inst%0d", i), got_dout[i], exp_dout);
        end

        if (hold) begin
            finished = 1'b0;
            for (int c = 0; c < 50 && !finished; c++) begin
                @(negedge clk);
                finished = !busy_s[0] && !busy_s[1];
            end
            check("hold_drain", finished, 1'b1);
        end
        check_mem($sformatf("mem_after_op%0d", op));
    endtask

    initial begin
        logic [31:0] wa [4];
        logic [31:0] x;
        logic [1:0]  rop;

        for (int a = 0; a < 128; a++) ref_mem[a] = pat(a);
        exp_dout = '0;

        // Reset state and memory preload.
        init_mem = 1'b1;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        check_outputs_zero("reset_state");
        n_rst = 1'b1;
        check_mem("mem_init");

        // WRITE then READ of the same word.
        run_cmd(WRT, 7'h05, 7'h00, 7'd0, 32'hDEADBEEF, 1'b0, 0);
        run_cmd(RD,  7'h05, 7'h00, 7'd0, 32'h0, 1'b0, 0);
        check("read_deadbeef_inst0", dout_s[0], 32'hDEADBEEF);
        check("read_deadbeef_inst1", dout_s[1], 32'hDEADBEEF);

        // READ with a stray start pulse in cycle 3.
        run_cmd(RD, 7'h05, 7'h00, 7'd0, 32'h0, 1'b0, 3);

        // COPY across the top of the address space.
        wa = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        run_cmd(WRT, 7'h7E, 7'h00, 7'd0, wa[0], 1'b0, 0);
        run_cmd(WRT, 7'h7F, 7'h00, 7'd0, wa[1], 1'b0, 0);
        run_cmd(WRT, 7'h00, 7'h00, 7'd0, wa[2], 1'b0, 0);
        run_cmd(WRT, 7'h01, 7'h00, 7'd0, wa[3], 1'b0, 0);
        run_cmd(CPY, 7'h7E, 7'h10, 7'd3, 32'h0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("copy_dst10_inst%0d", i), mem[i][7'h10], wa[0]);
            check($sformatf("copy_dst13_inst%0d", i), mem[i][7'h13], wa[3]);
            check($sformatf("copy_dout_inst%0d", i), dout_s[i], wa[3]);
        end

        // Overlapping COPY propagates the first source word.
        x = 32'h1234ABCD;
        run_cmd(WRT, 7'h20, 7'h00, 7'd0, x, 1'b0, 0);
        run_cmd(CPY, 7'h20, 7'h21, 7'd2, 32'h0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("overlap21_inst%0d", i), mem[i][7'h21], x);
            check($sformatf("overlap22_inst%0d", i), mem[i][7'h22], x);
            check($sformatf("overlap23_inst%0d", i), mem[i][7'h23], x);
        end

        // Reset during RD_WAIT of a COPY.
        @(negedge clk);
        op_code = CPY; address_one = 7'h30; address_two = 7'h40; length = 7'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 check_outputs_zero("reset_mid_copy");
        @(posedge clk);
        #1 check_outputs_zero("reset_held");
        @(negedge clk);
        n_rst = 1'b1;
        exp_dout = '0;
        check_mem("mem_after_abort");
        run_cmd(NOP, 7'h00, 7'h00, 7'd0, 32'h0, 1'b0, 0);

        // Back-to-back READ with start held high through DONE.
        run_cmd(RD, 7'h21, 7'h00, 7'd0, 32'h0, 1'b1, 0);

        // Randomised command mix.
        for (int t = 0; t < 25; t++) begin
            rop = 2'($urandom_range(0, 3));
            run_cmd(rop, 7'($urandom), 7'($urandom), 7'($urandom_range(0, 7)), $urandom, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_datapath_ctrl.md
# sram_datapath_ctrl

Parametrised successor to the original SRAM datapath block. It accepts one command at a time (NOP, READ, WRITE, multi-word COPY) through a start/busy/done handshake and sequences the single-port SRAM read/write strobes. It also handles a configurable SRAM read latency and returns read data on `data_out`. It sits between the top-level control FSM and the SRAM model.

## Interface

Parameters:
- `DATA_W`, 32, SRAM word width.
- `ADDR_W`, 7, SRAM address width.
- `LEN_W`, 7, width of the COPY length field.
- `RD_LAT`, 1, cycles from `sram_re` asserted to `sram_rdata` valid; legal range ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  command request; accepted only when `busy`=0.
- `op_code`  in  2  00 NOP, 01 READ, 10 WRITE, 11 COPY.
- `address_one`  in  ADDR_W  READ/WRITE address; COPY source base.
- `address_two`  in  ADDR_W  COPY destination base; ignored otherwise.
- `length`  in  LEN_W  COPY transfers `length`+1 words; ignored otherwise.
- `data_in`  in  DATA_W  WRITE data.
- `data_out`  out  DATA_W  last word read from SRAM; held until the next read capture.
- `busy`  out  1  high from the cycle after acceptance through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `sram_re`  out  1  SRAM read strobe.
- `sram_we`  out  1  SRAM write strobe.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data.

## Operation

- **Reset (`n_rst`=0, immediate):**
  - state IDLE;
  - `data_out`=0, `busy`=0, `done`=0;
  - `sram_re`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0;
  - internal counters and latched command cleared.
- **States:** IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
- **Acceptance:** in IDLE, `start`=1 latches `op_code`, both addresses, `length` and `data_in`. `start` while `busy`=1 is ignored; no queuing.
- **Dispatch from IDLE:**
  - NOP → DONE.
  - READ → RD_ISSUE.
  - WRITE → WR.
  - COPY → RD_ISSUE, with word counter = `length`.
- **RD_ISSUE (one cycle):** `sram_re`=1, `sram_addr`=source address → RD_WAIT.
- **RD_WAIT (exactly RD_LAT cycles, latency counter):**
  - `sram_rdata` is registered into `data_out` and into the internal copy buffer at the end of the last cycle.
  - Next state: READ → DONE; COPY → WR.
- **WR (one cycle):**
  - `sram_we`=1.
  - `sram_addr`: latched `address_one` for WRITE, destination address for COPY.
  - `sram_wdata`: latched `data_in` for WRITE, copy buffer for COPY.
  - WRITE → DONE.
  - COPY, counter=0 → DONE.
  - COPY, counter≠0 → decrement counter, increment source and destination by 1 modulo 2^ADDR_W, → RD_ISSUE.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Strobes:** `sram_re` and `sram_we` are never high in the same cycle. Both are 0 in IDLE, RD_WAIT and DONE.
- **Address wrap-around:** address FF…F + 1 wraps to 0; this is not an error.
- **Overlapping COPY:** proceeds word by word in ascending order with no hazard protection. For destination = source+1, the source's first word propagates through the whole range; this is defined, required behaviour.
- **Reset mid-operation:** the operation is aborted with no `done` pulse. SRAM contents already written stay written.

## Timing

- Start is sampled at edge 0; `busy`=1 from cycle 1.
- NOP: DONE in cycle 1; IDLE in cycle 2.
- WRITE: WR in cycle 1; DONE in cycle 2.
- READ:
  - RD_ISSUE in cycle 1; RD_WAIT in cycles 2..1+RD_LAT.
  - DONE in cycle 2+RD_LAT, with `data_out` already valid in that cycle.
- COPY of N words: each word takes 2+RD_LAT cycles; DONE in cycle N·(2+RD_LAT)+1.
- `start` is accepted again in the first cycle back in IDLE; the earliest re-acceptance is one cycle after DONE.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Structure

- **Package `sram_dp_pkg`:**
  - `op_t` enum (OP_NOP=2'b00, OP_READ=2'b01, OP_WRITE=2'b10, OP_COPY=2'b11);
  - `state_t` enum of the five states.
- **Sub-module `flex_counter`:** parametrised rollover counter with clear/enable and rollover flag. Two instances:
  - RD_LAT latency timer;
  - COPY word counter.
- **Top:** FSM, address and data registers, strobe decode.

## Test plan

- Reset mid-COPY: assert `n_rst`=0 during RD_WAIT → all outputs 0 in the same cycle, no `done`. After release, IDLE, and the next NOP completes normally.
- WRITE then READ, RD_LAT=1: write 32'hDEADBEEF to address 7'h05, then read 7'h05.
  - `sram_we` high in cycle 1; `done` in cycle 2.
  - READ `done` in cycle 3 with `data_out`=32'hDEADBEEF.
- READ with RD_LAT=3 → `sram_re` high only in cycle 1; `done` in cycle 5. A `start` pulse asserted in cycle 3 is ignored.
- COPY, `length`=3, source 7'h7E, destination 7'h10, source words A,B,C,D:
  - source addresses 7E,7F,00,01 are read (wrap-around);
  - destinations 10..13 are written with A..D;
  - `done` in cycle 13 (RD_LAT=1), with `data_out`=D.
- Overlapping COPY: source 7'h20, destination 7'h21, `length`=2, word at 20 is X → 21, 22 and 23 all end up equal to X.
- Back-to-back: a second READ with `start` held high through DONE is accepted in the first IDLE cycle. Strobes never overlap; NOP gives `done` in cycle 1.
